// File: rtl/arm_pkg.sv
// Shared ARM pipeline definitions: instruction field widths, mode codes,
// data-processing opcodes, EX-stage command codes and condition codes.
// Helpers:
//   exec_of_opcode : data-processing opcode -> EX command
//   cond_pass      : ARM condition code evaluated against {N,Z,C,V}
package arm_pkg;

  localparam int INSTR_W = 32;
  localparam int SHIFT_W = 12;
  localparam int IMM24_W = 24;
  localparam int EXEC_W  = 4;
  localparam int SR_W    = 4;

  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [EXEC_W-1:0] EXEC_NOP = 4'b0000;
  localparam logic [EXEC_W-1:0] EXEC_MOV = 4'b0001;
  localparam logic [EXEC_W-1:0] EXEC_ADD = 4'b0010;
  localparam logic [EXEC_W-1:0] EXEC_ADC = 4'b0011;
  localparam logic [EXEC_W-1:0] EXEC_SUB = 4'b0100;
  localparam logic [EXEC_W-1:0] EXEC_SBC = 4'b0101;
  localparam logic [EXEC_W-1:0] EXEC_AND = 4'b0110;
  localparam logic [EXEC_W-1:0] EXEC_ORR = 4'b0111;
  localparam logic [EXEC_W-1:0] EXEC_EOR = 4'b1000;
  localparam logic [EXEC_W-1:0] EXEC_MVN = 4'b1001;
  localparam logic [EXEC_W-1:0] EXEC_CMP = 4'b0100;
  localparam logic [EXEC_W-1:0] EXEC_TST = 4'b0110;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Opcodes without an EX command (RSB, RSC, TEQ, CMN, BIC) map to NOP.
  function automatic logic [EXEC_W-1:0] exec_of_opcode(input logic [3:0] opcode);
    logic [EXEC_W-1:0] cmd;
    case (opcode)
      OP_MOV:  cmd = EXEC_MOV;
      OP_MVN:  cmd = EXEC_MVN;
      OP_ADD:  cmd = EXEC_ADD;
      OP_ADC:  cmd = EXEC_ADC;
      OP_SUB:  cmd = EXEC_SUB;
      OP_SBC:  cmd = EXEC_SBC;
      OP_AND:  cmd = EXEC_AND;
      OP_ORR:  cmd = EXEC_ORR;
      OP_EOR:  cmd = EXEC_EOR;
      OP_CMP:  cmd = EXEC_CMP;
      OP_TST:  cmd = EXEC_TST;
      default: cmd = EXEC_NOP;
    endcase
    return cmd;
  endfunction

  // sr is {N,Z,C,V}; NV never passes.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [SR_W-1:0] sr);
    logic n, z, c, v, ok;
    {n, z, c, v} = sr;
    case (cond)
      COND_EQ: ok = z;
      COND_NE: ok = ~z;
      COND_CS: ok = c;
      COND_CC: ok = ~c;
      COND_MI: ok = n;
      COND_PL: ok = ~n;
      COND_VS: ok = v;
      COND_VC: ok = ~v;
      COND_HI: ok = c & ~z;
      COND_LS: ok = ~c | z;
      COND_GE: ok = (n == v);
      COND_LT: ok = (n != v);
      COND_GT: ok = ~z & (n == v);
      COND_LE: ok = z | (n != v);
      COND_AL: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/id_stage_pipelined_if.sv
// IF->ID handoff and ID->EX pipeline-register bundle of the decode stage.
//   master : upstream/downstream side (drives instruction, in_valid, ex_ready)
//   slave  : the decode stage (drives id_ready and the ID/EX outputs)
interface id_stage_pipelined_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_AW = 4
);
  logic              in_valid;
  logic [ADDR_W-1:0] pc_in;
  logic [31:0]       instruction;
  logic              id_ready;
  logic              ex_ready;

  logic              out_valid;
  logic              wb_en_out;
  logic              mem_r_en;
  logic              mem_w_en;
  logic              b;
  logic              s;
  logic              imm;
  logic              two_src;
  logic [3:0]        exec_cmd;
  logic [DATA_W-1:0] val_r_n;
  logic [DATA_W-1:0] val_r_m;
  logic [REG_AW-1:0] dest;
  logic [REG_AW-1:0] src_1;
  logic [REG_AW-1:0] src_2;
  logic [11:0]       shift_operand;
  logic [23:0]       signed_imm_24;
  logic [ADDR_W-1:0] pc_out;

  modport master (
    output in_valid, pc_in, instruction, ex_ready,
    input  id_ready, out_valid, wb_en_out, mem_r_en, mem_w_en, b, s, imm,
           two_src, exec_cmd, val_r_n, val_r_m, dest, src_1, src_2,
           shift_operand, signed_imm_24, pc_out
  );

  modport slave (
    input  in_valid, pc_in, instruction, ex_ready,
    output id_ready, out_valid, wb_en_out, mem_r_en, mem_w_en, b, s, imm,
           two_src, exec_cmd, val_r_n, val_r_m, dest, src_1, src_2,
           shift_operand, signed_imm_24, pc_out
  );
endinterface

// File: rtl/id_register_file.sv
// Architectural register file: one write port, two combinational read ports
// with write-through bypass (a same-cycle write is visible on the read).
//   clk, rst          : clock, asynchronous active-low reset (clears all)
//   we/waddr/wdata    : write port, committed on the rising edge
//   raddr_a/rdata_a   : read port A
//   raddr_b/rdata_b   : read port B
module id_register_file #(
  parameter int DATA_W    = 32,
  parameter int REG_COUNT = 16,
  parameter int AW        = $clog2(REG_COUNT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs_r [REG_COUNT];

  // Register storage: cleared on reset, written on the rising edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs_r[i] <= '0;
    end else if (we) begin
      regs_r[waddr] <= wdata;
    end
  end

  assign rdata_a = (we && (waddr == raddr_a)) ? wdata : regs_r[raddr_a];
  assign rdata_b = (we && (waddr == raddr_b)) ? wdata : regs_r[raddr_b];

endmodule

// File: rtl/id_stage_pipelined.sv
// ARM decode stage: field/control decode, register read with bypass,
// condition check against sr, RAW hazard detection against in-flight
// destinations, and the ID/EX pipeline register (flush > hold > bubble > load).
//   clk, rst        : clock, asynchronous active-low reset
//   bus (slave)     : IF handoff, id_ready, ex_ready and all ID/EX outputs
//   flush           : taken branch, loads a bubble
//   sr              : status flags {N,Z,C,V}
//   wb_en/dest/value: register-file write port
//   haz_en/haz_dest : pending writeback destinations (EX, MEM, ...)
module id_stage_pipelined
  import arm_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int REG_COUNT = 16,
  parameter int HAZ_PORTS = 2,
  localparam int REG_AW   = $clog2(REG_COUNT)
) (
  input  logic                        clk,
  input  logic                        rst,
  id_stage_pipelined_if.slave         bus,
  input  logic                        flush,
  input  logic [SR_W-1:0]             sr,
  input  logic                        wb_en,
  input  logic [REG_AW-1:0]           wb_dest,
  input  logic [DATA_W-1:0]           wb_value,
  input  logic [HAZ_PORTS-1:0]        haz_en,
  input  logic [HAZ_PORTS*REG_AW-1:0] haz_dest
);

  typedef struct packed {
    logic                out_valid;
    logic                wb_en_out;
    logic                mem_r_en;
    logic                mem_w_en;
    logic                b;
    logic                s;
    logic                imm;
    logic                two_src;
    logic [EXEC_W-1:0]   exec_cmd;
    logic [DATA_W-1:0]   val_r_n;
    logic [DATA_W-1:0]   val_r_m;
    logic [REG_AW-1:0]   dest;
    logic [REG_AW-1:0]   src_1;
    logic [REG_AW-1:0]   src_2;
    logic [SHIFT_W-1:0]  shift_operand;
    logic [IMM24_W-1:0]  signed_imm_24;
    logic [ADDR_W-1:0]   pc_out;
  } idex_t;

  logic [3:0]        cond_s;
  logic [1:0]        mode_s;
  logic              i_bit_s;
  logic [3:0]        opcode_s;
  logic              s_bit_s;
  logic [REG_AW-1:0] rn_s, rd_s, rm_s, src_2_s;
  logic              store_s, two_src_s, cond_ok_s, hazard_s;
  logic [EXEC_W-1:0] exec_cmd_s;
  logic              wb_s, mem_r_s, mem_w_s, b_s, s_s;
  logic [DATA_W-1:0] val_r_n_s, val_r_m_s;
  idex_t             decoded_s, idex_r;

  assign cond_s   = bus.instruction[31:28];
  assign mode_s   = bus.instruction[27:26];
  assign i_bit_s  = bus.instruction[25];
  assign opcode_s = bus.instruction[24:21];
  assign s_bit_s  = bus.instruction[20];
  assign rn_s     = bus.instruction[16 +: REG_AW];
  assign rd_s     = bus.instruction[12 +: REG_AW];
  assign rm_s     = bus.instruction[0 +: REG_AW];

  // A store reads its data register Rd as the second source.
  assign store_s   = (mode_s == MODE_MEM) & ~s_bit_s;
  assign src_2_s   = store_s ? rd_s : rm_s;
  assign two_src_s = ~i_bit_s | store_s;
  assign cond_ok_s = cond_pass(cond_s, sr);

  id_register_file #(
    .DATA_W    (DATA_W),
    .REG_COUNT (REG_COUNT),
    .AW        (REG_AW)
  ) u_rf (
    .clk     (clk),
    .rst     (rst),
    .we      (wb_en),
    .waddr   (wb_dest),
    .wdata   (wb_value),
    .raddr_a (rn_s),
    .rdata_a (val_r_n_s),
    .raddr_b (src_2_s),
    .rdata_b (val_r_m_s)
  );

  // Control decode by instruction class.
  always_comb begin
    exec_cmd_s = EXEC_NOP;
    wb_s       = 1'b0;
    mem_r_s    = 1'b0;
    mem_w_s    = 1'b0;
    b_s        = 1'b0;
    s_s        = 1'b0;
    case (mode_s)
      MODE_DP: begin
        exec_cmd_s = exec_of_opcode(opcode_s);
        wb_s       = ~((opcode_s == OP_CMP) | (opcode_s == OP_TST));
        s_s        = s_bit_s;
      end
      MODE_MEM: begin
        exec_cmd_s = EXEC_ADD;
        mem_r_s    = s_bit_s;
        wb_s       = s_bit_s;
        mem_w_s    = ~s_bit_s;
      end
      MODE_BR: b_s = 1'b1;
      default: exec_cmd_s = EXEC_NOP;
    endcase
  end

  // RAW hazard: any enabled in-flight destination matching a used source.
  always_comb begin
    hazard_s = 1'b0;
    for (int k = 0; k < HAZ_PORTS; k++) begin
      hazard_s = hazard_s | (haz_en[k] &
                 ((haz_dest[k*REG_AW +: REG_AW] == rn_s) |
                  (two_src_s & (haz_dest[k*REG_AW +: REG_AW] == src_2_s))));
    end
    hazard_s = hazard_s & bus.in_valid & (mode_s != MODE_BR);
  end

  // Assemble the decoded instruction; a failed condition issues as a no-effect op.
  always_comb begin
    decoded_s               = '0;
    decoded_s.out_valid     = 1'b1;
    decoded_s.wb_en_out     = wb_s & cond_ok_s;
    decoded_s.mem_r_en      = mem_r_s & cond_ok_s;
    decoded_s.mem_w_en      = mem_w_s & cond_ok_s;
    decoded_s.b             = b_s & cond_ok_s;
    decoded_s.s             = s_s & cond_ok_s;
    decoded_s.imm           = i_bit_s;
    decoded_s.two_src       = two_src_s;
    decoded_s.exec_cmd      = exec_cmd_s;
    decoded_s.val_r_n       = val_r_n_s;
    decoded_s.val_r_m       = val_r_m_s;
    decoded_s.dest          = rd_s;
    decoded_s.src_1         = rn_s;
    decoded_s.src_2         = src_2_s;
    decoded_s.shift_operand = bus.instruction[SHIFT_W-1:0];
    decoded_s.signed_imm_24 = bus.instruction[IMM24_W-1:0];
    decoded_s.pc_out        = bus.pc_in;
  end

  assign bus.id_ready = flush | (bus.ex_ready & ~hazard_s);

  // ID/EX pipeline register: flush, then hold, then bubble, then load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idex_r <= '0;
    end else if (flush) begin
      idex_r <= '0;
    end else if (!bus.ex_ready) begin
      idex_r <= idex_r;
    end else if (hazard_s || !bus.in_valid) begin
      idex_r <= '0;
    end else begin
      idex_r <= decoded_s;
    end
  end

  assign bus.out_valid     = idex_r.out_valid;
  assign bus.wb_en_out     = idex_r.wb_en_out;
  assign bus.mem_r_en      = idex_r.mem_r_en;
  assign bus.mem_w_en      = idex_r.mem_w_en;
  assign bus.b             = idex_r.b;
  assign bus.s             = idex_r.s;
  assign bus.imm           = idex_r.imm;
  assign bus.two_src       = idex_r.two_src;
  assign bus.exec_cmd      = idex_r.exec_cmd;
  assign bus.val_r_n       = idex_r.val_r_n;
  assign bus.val_r_m       = idex_r.val_r_m;
  assign bus.dest          = idex_r.dest;
  assign bus.src_1         = idex_r.src_1;
  assign bus.src_2         = idex_r.src_2;
  assign bus.shift_operand = idex_r.shift_operand;
  assign bus.signed_imm_24 = idex_r.signed_imm_24;
  assign bus.pc_out        = idex_r.pc_out;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Scoreboard bench for id_stage_pipelined: the driver computes the expected
// ID/EX contents from an instruction-level model and queues them; the
// monitor pops one entry after every rising edge and compares.
module tb_id_stage_pipelined;
  import arm_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [3:0]  sr;
  logic        wb_en;
  logic [3:0]  wb_dest;
  logic [31:0] wb_value;
  logic [1:0]  haz_en;
  logic [7:0]  haz_dest;

  id_stage_pipelined_if #(.DATA_W(32), .ADDR_W(32), .REG_AW(4)) bus ();

  id_stage_pipelined #(
    .DATA_W(32), .ADDR_W(32), .REG_COUNT(16), .HAZ_PORTS(2)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .flush(flush), .sr(sr),
    .wb_en(wb_en), .wb_dest(wb_dest), .wb_value(wb_value),
    .haz_en(haz_en), .haz_dest(haz_dest)
  );

  typedef struct packed {
    logic        ov, wbe, mr, mw, b, s, imm, two;
    logic [3:0]  exec;
    logic [31:0] vrn, vrm;
    logic [3:0]  dest, src1, src2;
    logic [11:0] shift;
    logic [23:0] simm;
    logic [31:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        model_out;
  logic [31:0] model_rf [16];
  int          vectors;
  int          miscompares;
  bit          mon_en;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t actual();
    exp_t a;
    a.ov = bus.out_valid;  a.wbe = bus.wb_en_out; a.mr = bus.mem_r_en;
    a.mw = bus.mem_w_en;   a.b = bus.b;           a.s = bus.s;
    a.imm = bus.imm;       a.two = bus.two_src;   a.exec = bus.exec_cmd;
    a.vrn = bus.val_r_n;   a.vrm = bus.val_r_m;   a.dest = bus.dest;
    a.src1 = bus.src_1;    a.src2 = bus.src_2;    a.shift = bus.shift_operand;
    a.simm = bus.signed_imm_24; a.pc = bus.pc_out;
    return a;
  endfunction

  // Condition table in terms of flag names.
  function automatic logic model_cond(input logic [3:0] cond, input logic [3:0] flags);
    logic n, z, c, v;
    n = flags[3]; z = flags[2]; c = flags[1]; v = flags[0];
    case (cond)
      4'h0: return z;            4'h1: return !z;
      4'h2: return c;            4'h3: return !c;
      4'h4: return n;            4'h5: return !n;
      4'h6: return v;            4'h7: return !v;
      4'h8: return c && !z;      4'h9: return !c || z;
      4'hA: return n == v;       4'hB: return n != v;
      4'hC: return !z && n == v; 4'hD: return z || n != v;
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] model_exec(input logic [3:0] op);
    case (op)
      4'b1101: return EXEC_MOV;  4'b1111: return EXEC_MVN;
      4'b0100: return EXEC_ADD;  4'b0101: return EXEC_ADC;
      4'b0010: return EXEC_SUB;  4'b0110: return EXEC_SBC;
      4'b0000: return EXEC_AND;  4'b1100: return EXEC_ORR;
      4'b0001: return EXEC_EOR;  4'b1010: return EXEC_CMP;
      4'b1000: return EXEC_TST;
      default: return EXEC_NOP;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] a);
    return (wb_en && wb_dest == a) ? wb_value : model_rf[a];
  endfunction

  function automatic exp_t model_decode();
    exp_t d;
    logic [31:0] ins;
    logic [1:0]  mode;
    logic        store;
    ins   = bus.instruction;
    mode  = ins[27:26];
    store = (mode == 2'b01) && !ins[20];
    d      = '0;
    d.ov   = 1'b1;
    d.imm  = ins[25];
    d.dest = ins[15:12];
    d.src1 = ins[19:16];
    d.src2 = store ? ins[15:12] : ins[3:0];
    d.two  = !ins[25] || store;
    d.vrn  = model_read(d.src1);
    d.vrm  = model_read(d.src2);
    d.shift = ins[11:0];
    d.simm  = ins[23:0];
    d.pc    = bus.pc_in;
    if (mode == 2'b00) begin
      d.exec = model_exec(ins[24:21]);
      d.wbe  = !(ins[24:21] == 4'b1010 || ins[24:21] == 4'b1000);
      d.s    = ins[20];
    end else if (mode == 2'b01) begin
      d.exec = EXEC_ADD;
      d.mr   = ins[20];
      d.wbe  = ins[20];
      d.mw   = !ins[20];
    end else if (mode == 2'b10) begin
      d.b = 1'b1;
    end
    if (!model_cond(ins[31:28], sr)) begin
      d.wbe = 1'b0; d.mr = 1'b0; d.mw = 1'b0; d.b = 1'b0; d.s = 1'b0;
    end
    return d;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic check_all(input string name, input exp_t act, input exp_t req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // One cycle: inputs already set at the falling edge.
  task automatic step();
    exp_t d, nxt;
    logic haz;
    d   = model_decode();
    haz = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (haz_en[k] && (haz_dest[k*4 +: 4] == d.src1 ||
                        (d.two && haz_dest[k*4 +: 4] == d.src2)))
        haz = 1'b1;
    end
    haz = haz && bus.in_valid && (bus.instruction[27:26] != 2'b10);
    #1;
    check("id_ready", {31'd0, bus.id_ready}, {31'd0, flush || (bus.ex_ready && !haz)});
    if (flush)                         nxt = '0;
    else if (!bus.ex_ready)            nxt = model_out;
    else if (haz || !bus.in_valid)     nxt = '0;
    else                               nxt = d;
    exp_q.push_back(nxt);
    model_out = nxt;
    @(posedge clk);
    if (wb_en) model_rf[wb_dest] = wb_value;
    @(negedge clk);
  endtask

  // Monitor: compare DUT outputs with the queued expectation after each edge.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL scoreboard: DUT output with no expectation queued, got %h", actual());
      end else begin
        check_all("idex", actual(), exp_q.pop_front());
      end
    end
  end

  task automatic idle_inputs();
    bus.in_valid = 1'b0; bus.pc_in = 32'd0; bus.instruction = 32'd0;
    bus.ex_ready = 1'b1; flush = 1'b0; sr = 4'd0;
    wb_en = 1'b0; wb_dest = 4'd0; wb_value = 32'd0;
    haz_en = 2'd0; haz_dest = 8'd0;
  endtask

  task automatic model_reset();
    model_out = '0;
    for (int i = 0; i < 16; i++) model_rf[i] = 32'd0;
  endtask

  initial begin
    vectors = 0; miscompares = 0; mon_en = 1'b0;
    idle_inputs();
    model_reset();
    rst = 1'b0;
    #1;
    check_all("reset_outputs", actual(), '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;

    // Preload R2=5, R3=7.
    wb_en = 1'b1; wb_dest = 4'd2; wb_value = 32'd5; step();
    wb_dest = 4'd3; wb_value = 32'd7; step();
    wb_en = 1'b0;

    // ADD R1,R2,R3.
    bus.in_valid = 1'b1; bus.instruction = 32'hE0821003; bus.pc_in = 32'h100;
    step();
    check("add_exec", {28'd0, bus.exec_cmd}, {28'd0, EXEC_ADD});
    check("add_vrn", bus.val_r_n, 32'd5);
    check("add_vrm", bus.val_r_m, 32'd7);
    check("add_dest", {28'd0, bus.dest}, 32'd1);
    check("add_flags", {29'd0, bus.two_src, bus.wb_en_out, bus.out_valid}, 32'd7);

    // Same-cycle write of R2 bypasses into the read.
    wb_en = 1'b1; wb_dest = 4'd2; wb_value = 32'h55;
    step();
    check("bypass_vrn", bus.val_r_n, 32'h55);
    wb_en = 1'b0;

    // Hazard on R3 for two cycles, then issue.
    haz_en = 2'b01; haz_dest = 8'h03;
    step();
    check("haz_ready1", {31'd0, bus.id_ready}, 32'd0);
    check("haz_valid1", {31'd0, bus.out_valid}, 32'd0);
    step();
    check("haz_valid2", {31'd0, bus.out_valid}, 32'd0);
    haz_en = 2'b00;
    step();
    check("haz_issue", {31'd0, bus.out_valid}, 32'd1);
    check("haz_vrm", bus.val_r_m, 32'd7);

    // ADDEQ with Z=0 fails its condition.
    bus.instruction = 32'h00821003; sr = 4'b0000;
    step();
    check("condfail", {26'd0, bus.out_valid, bus.wb_en_out, bus.mem_r_en,
                       bus.mem_w_en, bus.b, bus.s}, 32'h20);

    // Issue ADD, then hold three cycles while a write hits R2.
    bus.instruction = 32'hE0821003; sr = 4'b1110;
    step();
    bus.ex_ready = 1'b0; bus.instruction = 32'hE3A05001;
    wb_en = 1'b1; wb_dest = 4'd2; wb_value = 32'hAA;
    repeat (3) step();
    check("hold_vrn", bus.val_r_n, 32'h55);
    check("hold_ready", {31'd0, bus.id_ready}, 32'd0);
    wb_en = 1'b0;

    // Flush with a hazard present.
    bus.instruction = 32'hE0821003; haz_en = 2'b10; haz_dest = 8'h20; flush = 1'b1;
    step();
    check("flush_valid", {31'd0, bus.out_valid}, 32'd0);
    check("flush_ready", {31'd0, bus.id_ready}, 32'd1);
    flush = 1'b0; haz_en = 2'b00; bus.ex_ready = 1'b1;

    // Reset asynchronously in the middle of a stall.
    step();
    bus.ex_ready = 1'b0;
    step();
    mon_en = 1'b0;
    #2 rst = 1'b0;
    model_reset();
    #1;
    check_all("async_reset", actual(), '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
    bus.ex_ready = 1'b1; bus.instruction = 32'hE0810002;
    step();
    check("r1_after_reset", bus.val_r_n, 32'd0);

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] cond;
      cond = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hE;
      bus.instruction = {cond, 28'($urandom)};
      bus.pc_in    = $urandom;
      bus.in_valid = ($urandom_range(0, 7) != 0);
      bus.ex_ready = ($urandom_range(0, 5) != 0);
      flush        = ($urandom_range(0, 15) == 0);
      sr           = 4'($urandom);
      wb_en        = 1'($urandom);
      wb_dest      = 4'($urandom);
      wb_value     = $urandom;
      haz_en       = {($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0)};
      haz_dest     = 8'($urandom);
      step();
    end

    check("queue_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
